// File: rtl/io_pkg.sv
// Shared encodings for the IO lane scheduler: FSM states, lane indices, object-count defaults.
package io_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DECOMP = 2'b01,
    S_DRAIN  = 2'b11,
    S_CALC   = 2'b10
  } state_e;

  localparam int NUM_LANES     = 4;
  localparam int LANE_A        = 0;
  localparam int LANE_B        = 1;
  localparam int LANE_U        = 2;
  localparam int LANE_REST     = 3;
  localparam int LAST_OBJS_DEF = 4;

  // Object counter width, clamped to 2..8 bits.
  function automatic int obj_cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    if (w < 2) w = 2;
    if (w > 8) w = 8;
    return w;
  endfunction
endpackage

// File: rtl/io_lane_slot.sv
// One decompressor lane: registered byte, valid flag and sticky finish flag.
module io_lane_slot (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       word_hs,
  input  logic       clr,
  input  logic       fin_clr,
  input  logic       fin_set,
  input  logic [7:0] byte_in,
  input  logic       lane_ready,
  output logic [7:0] lane_data,
  output logic       lane_valid,
  output logic       finish,
  output logic       lane_hs
);
  assign lane_hs = lane_valid & lane_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_data  <= '0;
      lane_valid <= 1'b0;
      finish     <= 1'b0;
    end else begin
      // An abort outranks any handshake seen in the same cycle.
      if (clr)          lane_valid <= 1'b0;
      else if (word_hs) lane_valid <= !finish;
      else if (lane_hs) lane_valid <= 1'b0;
      if (word_hs && !clr) lane_data <= byte_in;
      if (clr || fin_clr)  finish <= 1'b0;
      else if (fin_set)    finish <= 1'b1;
    end
  end
endmodule

// File: rtl/io_lane_scheduler.sv
// Splits 32-bit words into four decompressor byte lanes and sequences IDLE/DECOMP/DRAIN/CALC.
// Optional idle watchdog enabled by defining IO_SCHED_WATCHDOG_EN.
module io_lane_scheduler
  import io_pkg::*;
#(
  parameter int LAST_OBJS   = LAST_OBJS_DEF,
  parameter int WDOG_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        int_req,
  input  logic        process,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [31:0] data_in,
  output logic [31:0] lane_data,
  output logic [3:0]  lane_valid,
  input  logic [3:0]  lane_ready,
  input  logic [3:0]  lane_eob,
  output logic [3:0]  start,
  output logic        next_obj,
  output logic [1:0]  phase,
  output logic        done,
  output logic        wdog_err
);
  localparam int CW = obj_cnt_w(LAST_OBJS);

  state_e          state;
  logic [3:0]      finish, lane_hs, eob_hs, fin_set;
  logic [CW-1:0]   obj_cnt;
  logic            word_hs, abort, go, clr, wdog_fire;

  assign phase      = state;
  assign word_ready = (state == S_DECOMP) && (lane_valid == 4'b0000);
  assign word_hs    = word_valid && word_ready;
  assign abort      = ((state == S_DECOMP) || (state == S_DRAIN)) && int_req && process;
  assign go         = (state == S_IDLE) && int_req && !process;
  assign clr        = abort || wdog_fire;
  assign eob_hs     = lane_hs & lane_eob;
  assign fin_set    = {eob_hs[LANE_REST] && (obj_cnt == CW'(LAST_OBJS - 1)),
                       eob_hs[LANE_U], eob_hs[LANE_B], eob_hs[LANE_A]};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_slot
    io_lane_slot u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .word_hs   (word_hs),
      .clr       (clr),
      .fin_clr   (go),
      .fin_set   (fin_set[i]),
      .byte_in   (data_in[8*i +: 8]),
      .lane_ready(lane_ready[i]),
      .lane_data (lane_data[8*i +: 8]),
      .lane_valid(lane_valid[i]),
      .finish    (finish[i]),
      .lane_hs   (lane_hs[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      obj_cnt  <= '0;
      next_obj <= 1'b0;
    end else begin
      next_obj <= eob_hs[LANE_REST] && !clr;
      if (go || clr)              obj_cnt <= '0;
      else if (eob_hs[LANE_REST]) obj_cnt <= obj_cnt + 1'b1;
    end
  end

`ifdef IO_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wcnt;

  assign wdog_fire = (state == S_DECOMP) && !word_hs && !abort && (wcnt == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          wcnt <= '0;
    else if (state != S_DECOMP || word_hs) wcnt <= '0;
    else                                   wcnt <= wcnt + 1'b1;
  end
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      start    <= 4'b0000;
      done     <= 1'b0;
      wdog_err <= 1'b0;
    end else begin
      start <= 4'b0000;
      done  <= 1'b0;
      if (wdog_fire) wdog_err <= 1'b1;
      case (state)
        S_IDLE: if (go) begin
          state <= S_DECOMP;
          start <= 4'b1111;
        end
        S_DECOMP: begin
          if (abort)                  state <= S_CALC;
          else if (wdog_fire)         state <= S_IDLE;
          else if (finish == 4'b1111) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (abort) state <= S_CALC;
          else if (lane_valid == 4'b0000) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        S_CALC:  if (!process) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_lane_scheduler.sv
// Self-checking bench for io_lane_scheduler: table-driven lane vectors plus hand sequences.
module tb_io_lane_scheduler;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        int_req = 1'b0, process = 1'b0, word_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  lane_ready = '0, lane_eob = '0;
  logic        word_ready, next_obj, done, wdog_err;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid, start;
  logic [1:0]  phase;

  io_lane_scheduler #(.LAST_OBJS(4), .WDOG_CYCLES(255)) dut (
    .clk(clk), .reset_n(reset_n), .int_req(int_req), .process(process),
    .word_valid(word_valid), .word_ready(word_ready), .data_in(data_in),
    .lane_data(lane_data), .lane_valid(lane_valid), .lane_ready(lane_ready),
    .lane_eob(lane_eob), .start(start), .next_obj(next_obj), .phase(phase),
    .done(done), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  typedef struct { logic [31:0] data; logic [3:0] valid; } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [31:0] word;
    logic [3:0]  eob;
    logic [3:0]  exp_valid;
    logic        exp_nobj;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_decomp();
    int_req = 1'b1; process = 1'b0;
    step();
    int_req = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [3:0] expv);
    sb_t s;
    int  n = 0;
    while (!word_ready && n < 20) begin step(); n++; end
    chk("word_ready_wait", {31'b0, word_ready}, 32'd1);
    word_valid = 1'b1; data_in = w;
    sbq.push_back('{data: w, valid: expv});
    step();
    word_valid = 1'b0;
    if (sbq.size() == 0) chk("sb_empty", 32'd0, 32'd1);
    else begin
      s = sbq.pop_front();
      chk("lane_data", lane_data, s.data);
      chk("lane_valid_load", {28'b0, lane_valid}, {28'b0, s.valid});
    end
  endtask

  initial begin
    int nobj = 0;
    vecs[0] = '{32'h44332211, 4'b0000, 4'b1111, 1'b0};
    vecs[1] = '{32'hA1B2C3D4, 4'b0010, 4'b1111, 1'b0};
    vecs[2] = '{32'h55667788, 4'b1000, 4'b1101, 1'b1};
    vecs[3] = '{32'h01020304, 4'b0001, 4'b1101, 1'b0};
    vecs[4] = '{32'hCAFEBABE, 4'b1100, 4'b1100, 1'b1};
    vecs[5] = '{32'h0F0E0D0C, 4'b1000, 4'b1000, 1'b1};
    vecs[6] = '{32'h13579BDF, 4'b1000, 4'b1000, 1'b1};

    step(); step();
    chk("rst_phase", {30'b0, phase}, 32'd0);
    chk("rst_lane_valid", {28'b0, lane_valid}, 32'd0);
    chk("rst_lane_data", lane_data, 32'd0);
    chk("rst_word_ready", {31'b0, word_ready}, 32'd0);
    chk("rst_start", {28'b0, start}, 32'd0);
    chk("rst_flags", {29'b0, next_obj, done, wdog_err}, 32'd0);
    reset_n = 1'b1;
    step();

    // int_req with process=1 in IDLE is ignored
    int_req = 1'b1; process = 1'b1;
    step();
    int_req = 1'b0; process = 1'b0;
    chk("idle_ignore_phase", {30'b0, phase}, 32'd0);
    chk("idle_ignore_start", {28'b0, start}, 32'd0);

    go_decomp();
    chk("go_start", {28'b0, start}, 32'hF);
    chk("go_phase", {30'b0, phase}, 32'd1);
    chk("go_word_ready", {31'b0, word_ready}, 32'd1);
    step();
    chk("start_pulse_end", {28'b0, start}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      send_word(vecs[i].word, vecs[i].exp_valid);
      // eob with no lane_ready must not be sampled
      lane_ready = 4'b0000; lane_eob = 4'b1111;
      step();
      chk("hold_valid", {28'b0, lane_valid}, {28'b0, vecs[i].exp_valid});
      chk("hold_word_ready", {31'b0, word_ready}, 32'd0);
      lane_ready = 4'b1111; lane_eob = vecs[i].eob;
      step();
      lane_ready = 4'b0000; lane_eob = 4'b0000;
      chk("drain_valid", {28'b0, lane_valid}, 32'd0);
      chk("next_obj", {31'b0, next_obj}, {31'b0, vecs[i].exp_nobj});
      chk("word_ready_back", {31'b0, word_ready}, 32'd1);
      if (next_obj) nobj++;
    end
    chk("next_obj_count", nobj, 32'd4);
    step();
    chk("drain_phase", {30'b0, phase}, 32'd3);
    chk("drain_done", {31'b0, done}, 32'd0);
    step();
    chk("idle_phase", {30'b0, phase}, 32'd0);
    chk("done_pulse", {31'b0, done}, 32'd1);
    step();
    chk("done_end", {31'b0, done}, 32'd0);

    // abort mid-DECOMP beats same-cycle lane handshakes
    go_decomp();
    chk("go2_start", {28'b0, start}, 32'hF);
    send_word(32'hDEADBEEF, 4'b1111);
    int_req = 1'b1; process = 1'b1; lane_ready = 4'b1111; lane_eob = 4'b1111;
    step();
    lane_ready = 4'b0000; lane_eob = 4'b0000;
    chk("abort_phase", {30'b0, phase}, 32'd2);
    chk("abort_valid", {28'b0, lane_valid}, 32'd0);
    chk("abort_next_obj", {31'b0, next_obj}, 32'd0);
    step();
    chk("calc_ignore", {30'b0, phase}, 32'd2);
    process = 1'b0;
    step();
    int_req = 1'b0;
    chk("calc_exit", {30'b0, phase}, 32'd0);
    chk("calc_exit_start", {28'b0, start}, 32'd0);

    go_decomp();
    send_word(32'h0BADF00D, 4'b1111);

    // asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", {28'b0, lane_valid}, 32'd0);
    chk("arst_data", lane_data, 32'd0);
    chk("arst_phase", {30'b0, phase}, 32'd0);
    chk("arst_word_ready", {31'b0, word_ready}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_phase", {30'b0, phase}, 32'd0);
    chk("post_rst_valid", {28'b0, lane_valid}, 32'd0);

    go_decomp();
`ifdef IO_SCHED_WATCHDOG_EN
    begin
      int n = 0;
      while (!wdog_err && n < 400) begin step(); n++; end
      chk("wdog_err", {31'b0, wdog_err}, 32'd1);
      chk("wdog_cycles", n, 32'd255);
      chk("wdog_phase", {30'b0, phase}, 32'd0);
      step();
      chk("wdog_sticky", {31'b0, wdog_err}, 32'd1);
    end
`else
    repeat (300) step();
    chk("no_wdog_err", {31'b0, wdog_err}, 32'd0);
    chk("no_wdog_phase", {30'b0, phase}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
